// File: rtl/entropy_codeword_gen_if.sv
// Sample-in / codeword-out handshake bundle for entropy_codeword_gen.
// The slave modport is the encoder's view; master is the producer/consumer side.
interface entropy_codeword_gen_if #(
  parameter int VAL_W  = 16,
  parameter int CODE_W = 48,
  parameter int LEN_W  = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [VAL_W-1:0]  in_val;
  logic [2:0]        in_rice_k;
  logic [2:0]        in_exp_k;
  logic [3:0]        in_switch_q;
  logic              in_is_ac_level;
  logic              in_is_minus;
  logic              out_valid;
  logic              out_ready;
  logic [CODE_W-1:0] out_code;
  logic [LEN_W-1:0]  out_len;
  logic              out_err;

  modport slave (
    input  in_valid, in_val, in_rice_k, in_exp_k, in_switch_q,
    input  in_is_ac_level, in_is_minus, out_ready,
    output in_ready, out_valid, out_code, out_len, out_err
  );

  modport master (
    output in_valid, in_val, in_rice_k, in_exp_k, in_switch_q,
    output in_is_ac_level, in_is_minus, out_ready,
    input  in_ready, out_valid, out_code, out_len, out_err
  );
endinterface

// File: rtl/entropy_codeword_gen.sv
// Three-stage ProRes hybrid Rice / exp-Golomb codeword generator with an
// optional trailing sign bit; valid/ready on both sides, full throughput.
module entropy_codeword_gen #(
  parameter int VAL_W  = 16,
  parameter int CODE_W = 48,
  parameter int LEN_W  = 6
) (
  input logic clk,
  input logic reset_n,
  entropy_codeword_gen_if.slave bus
);

  // Internal body/shift width leaves headroom for VAL_W+7 bit intermediates.
  localparam int          BW       = VAL_W + 8;
  localparam int          LNW      = $clog2(2 * BW + 4) + 1;
  localparam logic [31:0] CODE_LIM = 32'(CODE_W);
  localparam logic [31:0] LEN_SAT  = 32'((1 << LEN_W) - 1);

  logic              s1_valid_q, s1_valid_d;
  logic [VAL_W-1:0]  s1_val_q, s1_val_d;
  logic [2:0]        s1_rice_k_q, s1_rice_k_d;
  logic [2:0]        s1_exp_k_q, s1_exp_k_d;
  logic [3:0]        s1_switch_q_q, s1_switch_q_d;
  logic              s1_ac_q, s1_ac_d;
  logic              s1_minus_q, s1_minus_d;

  logic              s2_valid_q, s2_valid_d;
  logic              s2_eg_q, s2_eg_d;
  logic [BW-1:0]     s2_body_q, s2_body_d;
  logic [LNW-1:0]    s2_len_q, s2_len_d;
  logic [2:0]        s2_exp_k_q, s2_exp_k_d;
  logic              s2_ac_q, s2_ac_d;
  logic              s2_minus_q, s2_minus_d;

  logic              out_valid_q, out_valid_d;
  logic [CODE_W-1:0] out_code_q, out_code_d;
  logic [LEN_W-1:0]  out_len_q, out_len_d;
  logic              out_err_q, out_err_d;

  logic              s1_free, s2_free, s3_free;

  logic [VAL_W-1:0]  q1;
  logic              eg1;
  logic [BW-1:0]     val_x, one_k, rice_body, v_prime;
  logic [LNW-1:0]    rice_len;

  logic [LNW-1:0]    msb_n, eg_len, len2, len3;
  logic [BW:0]       code3;
  logic [31:0]       len3_w;
  logic              err3;

  // A stage may load when it is empty or its content is moving on this edge.
  assign s3_free      = !out_valid_q || bus.out_ready;
  assign s2_free      = !s2_valid_q || s3_free;
  assign s1_free      = !s1_valid_q || s2_free;
  assign bus.in_ready = s1_free;

  always_comb begin
    q1        = s1_val_q >> s1_rice_k_q;
    eg1       = q1 > VAL_W'(s1_switch_q_q);
    val_x     = BW'(s1_val_q);
    one_k     = BW'(1) << s1_rice_k_q;
    rice_body = one_k | (val_x & (one_k - BW'(1)));
    rice_len  = LNW'(q1) + LNW'(s1_rice_k_q) + LNW'(1);
    // Never negative in exp-Golomb mode because q > switch_q there.
    v_prime   = val_x - ((BW'(s1_switch_q_q) + BW'(1)) << s1_rice_k_q)
                + (BW'(1) << s1_exp_k_q);
  end

  always_comb begin
    msb_n = '0;
    for (int i = 0; i < BW; i++) begin
      if (s2_body_q[i]) msb_n = LNW'(i);
    end
    eg_len = (msb_n << 1) + LNW'(1) - LNW'(s2_exp_k_q);
    len2   = s2_eg_q ? eg_len : s2_len_q;
    len3   = len2 + LNW'(s2_ac_q);
    code3  = s2_ac_q ? {s2_body_q, s2_minus_q} : {1'b0, s2_body_q};
    len3_w = 32'(len3);
    err3   = len3_w > CODE_LIM;
  end

  always_comb begin
    s1_valid_d    = s1_valid_q;
    s1_val_d      = s1_val_q;
    s1_rice_k_d   = s1_rice_k_q;
    s1_exp_k_d    = s1_exp_k_q;
    s1_switch_q_d = s1_switch_q_q;
    s1_ac_d       = s1_ac_q;
    s1_minus_d    = s1_minus_q;
    s2_valid_d    = s2_valid_q;
    s2_eg_d       = s2_eg_q;
    s2_body_d     = s2_body_q;
    s2_len_d      = s2_len_q;
    s2_exp_k_d    = s2_exp_k_q;
    s2_ac_d       = s2_ac_q;
    s2_minus_d    = s2_minus_q;
    out_valid_d   = out_valid_q;
    out_code_d    = out_code_q;
    out_len_d     = out_len_q;
    out_err_d     = out_err_q;

    if (s1_free) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_val_d      = bus.in_val;
        s1_rice_k_d   = bus.in_rice_k;
        s1_exp_k_d    = bus.in_exp_k;
        s1_switch_q_d = bus.in_switch_q;
        s1_ac_d       = bus.in_is_ac_level;
        s1_minus_d    = bus.in_is_minus;
      end
    end

    if (s2_free) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_eg_d    = eg1;
        s2_body_d  = eg1 ? v_prime : rice_body;
        s2_len_d   = rice_len;
        s2_exp_k_d = s1_exp_k_q;
        s2_ac_d    = s1_ac_q;
        s2_minus_d = s1_minus_q;
      end
    end

    if (s3_free) begin
      out_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        out_err_d  = err3;
        out_code_d = err3 ? '0 : CODE_W'(code3);
        out_len_d  = (len3_w > LEN_SAT) ? '1 : LEN_W'(len3);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q    <= 1'b0;
      s1_val_q      <= '0;
      s1_rice_k_q   <= '0;
      s1_exp_k_q    <= '0;
      s1_switch_q_q <= '0;
      s1_ac_q       <= 1'b0;
      s1_minus_q    <= 1'b0;
      s2_valid_q    <= 1'b0;
      s2_eg_q       <= 1'b0;
      s2_body_q     <= '0;
      s2_len_q      <= '0;
      s2_exp_k_q    <= '0;
      s2_ac_q       <= 1'b0;
      s2_minus_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_code_q    <= '0;
      out_len_q     <= '0;
      out_err_q     <= 1'b0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_val_q      <= s1_val_d;
      s1_rice_k_q   <= s1_rice_k_d;
      s1_exp_k_q    <= s1_exp_k_d;
      s1_switch_q_q <= s1_switch_q_d;
      s1_ac_q       <= s1_ac_d;
      s1_minus_q    <= s1_minus_d;
      s2_valid_q    <= s2_valid_d;
      s2_eg_q       <= s2_eg_d;
      s2_body_q     <= s2_body_d;
      s2_len_q      <= s2_len_d;
      s2_exp_k_q    <= s2_exp_k_d;
      s2_ac_q       <= s2_ac_d;
      s2_minus_q    <= s2_minus_d;
      out_valid_q   <= out_valid_d;
      out_code_q    <= out_code_d;
      out_len_q     <= out_len_d;
      out_err_q     <= out_err_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_code  = out_code_q;
  assign bus.out_len   = out_len_q;
  assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_entropy_codeword_gen.sv
// Scoreboard bench: two encoder instances (CODE_W=48 and CODE_W=16) fed the
// same stream; expected codewords come from an integer reference of the codebook.
module tb_entropy_codeword_gen;

  typedef struct {
    int v; int k; int e; int sq; bit ac; bit minus;
  } stim_t;

  typedef struct {
    longint code; int len; bit err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ac, in_minus, out_ready;
  logic [15:0] in_val;
  logic [2:0]  in_rice_k, in_exp_k;
  logic [3:0]  in_switch_q;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;

  entropy_codeword_gen_if #(.VAL_W(16), .CODE_W(48), .LEN_W(6)) bus_a ();
  entropy_codeword_gen_if #(.VAL_W(16), .CODE_W(16), .LEN_W(5)) bus_b ();

  assign bus_a.in_valid       = in_valid;
  assign bus_a.in_val         = in_val;
  assign bus_a.in_rice_k      = in_rice_k;
  assign bus_a.in_exp_k       = in_exp_k;
  assign bus_a.in_switch_q    = in_switch_q;
  assign bus_a.in_is_ac_level = in_ac;
  assign bus_a.in_is_minus    = in_minus;
  assign bus_a.out_ready      = out_ready;
  assign bus_b.in_valid       = in_valid;
  assign bus_b.in_val         = in_val;
  assign bus_b.in_rice_k      = in_rice_k;
  assign bus_b.in_exp_k       = in_exp_k;
  assign bus_b.in_switch_q    = in_switch_q;
  assign bus_b.in_is_ac_level = in_ac;
  assign bus_b.in_is_minus    = in_minus;
  assign bus_b.out_ready      = out_ready;

  entropy_codeword_gen #(.VAL_W(16), .CODE_W(48), .LEN_W(6)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a));
  entropy_codeword_gen #(.VAL_W(16), .CODE_W(16), .LEN_W(5)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b));

  task automatic check(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Codebook straight from its arithmetic definition.
  function automatic exp_t model(input stim_t s, input int code_w, input int len_w);
    exp_t r; longint q, body, vp; int len, n, sat;
    q = longint'(s.v >> s.k);
    if (q <= longint'(s.sq)) begin
      body = (longint'(1) << s.k) + longint'(s.v % (1 << s.k));
      len  = int'(q) + 1 + s.k;
    end else begin
      vp   = longint'(s.v) - longint'((s.sq + 1) * (1 << s.k)) + longint'(1 << s.e);
      n    = $clog2(vp + 1) - 1;
      body = vp;
      len  = 2 * n - s.e + 1;
    end
    if (s.ac) begin
      body = body * 2 + longint'(s.minus);
      len  = len + 1;
    end
    sat = (1 << len_w) - 1;
    if (len > code_w) begin
      r.err = 1'b1; r.code = 0; r.len = (len > sat) ? sat : len;
    end else begin
      r.err = 1'b0; r.code = body; r.len = len;
    end
    return r;
  endfunction

  function automatic stim_t mk_s(input int v, input int k, input int e, input int sq,
                                 input bit ac, input bit minus);
    stim_t s;
    s.v = v; s.k = k; s.e = e; s.sq = sq; s.ac = ac; s.minus = minus;
    return s;
  endfunction

  function automatic exp_t mk_e(input longint c, input int l, input bit err);
    exp_t r;
    r.code = c; r.len = l; r.err = err;
    return r;
  endfunction

  // Presents one sample, waits (bounded) for acceptance, returns at edge+1.
  task automatic send(input stim_t s, input exp_t ea, input exp_t eb, output int waited);
    int t;
    in_val      = 16'(s.v);
    in_rice_k   = 3'(s.k);
    in_exp_k    = 3'(s.e);
    in_switch_q = 4'(s.sq);
    in_ac       = s.ac;
    in_minus    = s.minus;
    in_valid    = 1'b1;
    t = 0;
    @(negedge clk);
    while (!bus_a.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("accept_timeout", 1, 0);
    qa.push_back(ea);
    qb.push_back(eb);
    waited = t;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_m(input stim_t s, output int waited);
    send(s, model(s, 48, 6), model(s, 16, 5), waited);
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((qa.size() != 0 || qb.size() != 0) && t < 500) begin
      @(posedge clk);
      t++;
    end
    if (t >= 500) check("drain_timeout", 1, 0);
    #1;
  endtask

  bit            stall_a = 0, stall_b = 0;
  logic [47:0]   h_code_a;
  logic [15:0]   h_code_b;
  logic [5:0]    h_len_a;
  logic [4:0]    h_len_b;
  logic          h_err_a, h_err_b;

  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      stall_a = 0;
    end else begin
      if (stall_a) begin
        check("hold_a_valid", longint'(bus_a.out_valid), 1);
        check("hold_a_code", longint'(bus_a.out_code), longint'(h_code_a));
        check("hold_a_len", longint'(bus_a.out_len), longint'(h_len_a));
        check("hold_a_err", longint'(bus_a.out_err), longint'(h_err_a));
      end
      if (bus_a.out_valid && out_ready) begin
        if (qa.size() == 0) check("unexpected_a", 1, 0);
        else begin
          e = qa.pop_front();
          check("code_a", longint'(bus_a.out_code), e.code);
          check("len_a", longint'(bus_a.out_len), longint'(e.len));
          check("err_a", longint'(bus_a.out_err), longint'(e.err));
        end
      end
      stall_a  = bus_a.out_valid && !out_ready;
      h_code_a = bus_a.out_code; h_len_a = bus_a.out_len; h_err_a = bus_a.out_err;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      stall_b = 0;
    end else begin
      if (stall_b) begin
        check("hold_b_valid", longint'(bus_b.out_valid), 1);
        check("hold_b_code", longint'(bus_b.out_code), longint'(h_code_b));
        check("hold_b_len", longint'(bus_b.out_len), longint'(h_len_b));
      end
      if (bus_b.out_valid && out_ready) begin
        if (qb.size() == 0) check("unexpected_b", 1, 0);
        else begin
          e = qb.pop_front();
          check("code_b", longint'(bus_b.out_code), e.code);
          check("len_b", longint'(bus_b.out_len), longint'(e.len));
          check("err_b", longint'(bus_b.out_err), longint'(e.err));
        end
      end
      stall_b  = bus_b.out_valid && !out_ready;
      h_code_b = bus_b.out_code; h_len_b = bus_b.out_len; h_err_b = bus_b.out_err;
    end
  end

  initial begin
    int w, wsum, lat;
    bit rand_done;
    stim_t s;

    reset_n = 1'b0; in_valid = 1'b0; in_val = '0; in_rice_k = '0; in_exp_k = '0;
    in_switch_q = '0; in_ac = 1'b0; in_minus = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", longint'(bus_a.in_ready), 1);
    check("rst_out_valid", longint'(bus_a.out_valid), 0);
    check("rst_out_code", longint'(bus_a.out_code), 0);
    check("rst_out_len", longint'(bus_a.out_len), 0);
    check("rst_out_err", longint'(bus_a.out_err), 0);
    align();

    // DC Rice plus first-sample latency
    send(mk_s(5, 2, 0, 3, 0, 0), mk_e(5, 4, 0), mk_e(5, 4, 0), w);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus_a.out_valid && lat < 10);
    check("latency", longint'(lat), 3);
    align();

    send(mk_s(2, 0, 0, 3, 1, 1), mk_e(3, 4, 0), mk_e(3, 4, 0), w);
    send(mk_s(2, 0, 0, 3, 1, 0), mk_e(2, 4, 0), mk_e(2, 4, 0), w);
    send(mk_s(5, 0, 0, 2, 0, 0), mk_e(3, 3, 0), mk_e(3, 3, 0), w);
    send(mk_s(10, 1, 1, 1, 0, 0), mk_e(8, 6, 0), mk_e(8, 6, 0), w);
    // Overflow only in the 16-bit instance; length 32 saturates to 31 there.
    send(mk_s(65535, 0, 0, 0, 1, 1), mk_e(131071, 32, 0), mk_e(0, 31, 1), w);
    // Mode boundaries: q == switch_q (Rice) and q == switch_q+1 (first exp-Golomb)
    send_m(mk_s(15 * 128 + 127, 7, 7, 15, 0, 0), w);
    send_m(mk_s(16 * 128, 7, 7, 15, 1, 0), w);
    send_m(mk_s(0, 0, 0, 0, 0, 0), w);
    drain();

    // Backpressure: out_ready low for cycles 4-9 of an 8-sample burst
    wsum = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send_m(mk_s(100 + 37 * i, i % 8, (i + 3) % 8, i, i[0], i[1]), w);
          wsum += w;
        end
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    check("bp_in_ready_fell", longint'(wsum > 0), 1);
    drain();

    // Sustained throughput with no backpressure
    wsum = 0;
    for (int i = 0; i < 10; i++) begin
      send_m(mk_s(int'($urandom_range(0, 4095)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), 1'b0, 1'b0), w);
      wsum += w;
    end
    check("throughput_stalls", longint'(wsum), 0);
    drain();

    // Reset with three samples in flight
    for (int i = 0; i < 3; i++) send_m(mk_s(7 + i, 1, 1, 2, 0, 0), w);
    #2 reset_n = 1'b0;
    #1 check("async_rst_valid", longint'(bus_a.out_valid), 0);
    qa.delete();
    qb.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_stale_out", longint'(bus_a.out_valid), 0);
    end
    align();
    send(mk_s(0, 0, 0, 0, 0, 0), mk_e(1, 1, 0), mk_e(1, 1, 0), w);
    drain();

    // Randomised stream under random backpressure
    rand_done = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          s = mk_s(int'($urandom_range(0, 65535) >> $urandom_range(0, 16)),
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
          send_m(s, w);
          if ($urandom_range(0, 3) == 0) align();
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check("final_queue_a", longint'(qa.size()), 0);
    check("final_queue_b", longint'(qb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
